// File: rtl/imemory_pipe_if.sv
// Fetch and program-load bundle for imemory_pipe. The fetch/loader side is the
// master; the instruction memory is the slave.
interface imemory_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             read;
  logic [WIDTH-1:0] address;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] instruction;
  logic             fault;

  logic             prog_start;
  logic             prog_valid;
  logic [WIDTH-1:0] prog_data;
  logic             prog_last;
  logic             prog_busy;
  logic             prog_done;
  logic [CW-1:0]    prog_count;

  modport master (
    output read, address, prog_start, prog_valid, prog_data, prog_last,
    input  ready, valid, instruction, fault, prog_busy, prog_done, prog_count
  );

  modport slave (
    input  read, address, prog_start, prog_valid, prog_data, prog_last,
    output ready, valid, instruction, fault, prog_busy, prog_done, prog_count
  );
endinterface

// File: rtl/imemory_pipe.sv
// Pipelined instruction memory: byte-addressed fetch port with alignment/range
// fault detection and a streaming loader that fills the array from word 0.
//   state  | meaning
//   S_IDLE | fetch port open, loader waiting for prog_start
//   S_LOAD | loader writing words in order, fetch port stalled
module imemory_pipe #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input logic           clk,
  input logic           rst_n,
  imemory_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic             r_pv [LATENCY];
  logic             r_pf [LATENCY];
  logic [WIDTH-1:0] r_pd [LATENCY];

  logic          w_accept;
  logic          w_range_fault;
  logic          w_fault;
  logic          w_we;
  logic [AW-1:0] w_idx;

  assign w_idx = bus.address[AW+1:2];

  generate
    if (WIDTH > AW + 2) begin : g_range
      assign w_range_fault = |bus.address[WIDTH-1:AW+2];
    end else begin : g_no_range
      assign w_range_fault = 1'b0;
    end
  endgenerate

  assign w_fault  = (bus.address[1:0] != 2'b00) || w_range_fault;
  assign w_accept = bus.read && (r_state == S_IDLE);
  assign w_we     = (r_state == S_LOAD) && bus.prog_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.prog_start) begin
            r_state  <= S_LOAD;
            r_wr_ptr <= '0;
            r_count  <= '0;
          end
        end
        S_LOAD: begin
          if (bus.prog_valid) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count  <= r_count + CW'(1);
            // Filling the last word ends the load even without prog_last.
            if (bus.prog_last || (r_wr_ptr == LAST_IDX)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array is deliberately not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= bus.prog_data;
    end
  end

  // Data is captured at accept time, so a load starting later cannot alter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pf[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pf[0] <= w_accept && w_fault;
      r_pd[0] <= (w_accept && !w_fault) ? r_mem[w_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pf[i] <= r_pf[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign bus.ready       = (r_state == S_IDLE);
  assign bus.prog_busy   = (r_state == S_LOAD);
  assign bus.prog_done   = r_done;
  assign bus.prog_count  = r_count;
  assign bus.valid       = r_pv[LATENCY-1];
  assign bus.fault       = r_pf[LATENCY-1];
  assign bus.instruction = r_pd[LATENCY-1];
endmodule
